// File: rtl/ntsc_composite_enc.sv
// NTSC composite encoder: turns generator timing plus a 3-bit RGB pixel into an
// 8-bit DAC code through a fixed two-stage pipeline (mode/colour, then modulate).
module ntsc_composite_enc #(
  parameter logic [7:0] C_SYNC_LV   = 8'd0,
  parameter logic [7:0] C_BLANK_LV  = 8'd72,
  parameter logic [7:0] C_BURST_AMP = 8'd28,
  parameter logic [2:0] C_BURST_HUE = 3'd4
) (
  input  logic       CK_i,
  input  logic       RST_i,
  input  logic       CK_EE_i,
  input  logic       XSYNC_i,
  input  logic       XBLK_i,
  input  logic       CBURST_NOW_i,
  input  logic [2:0] CPHs_i,
  input  logic [2:0] PIX_RGBs_i,
  output logic [7:0] DAC_o,
  output logic       XSYNC_o
);

  typedef enum logic [1:0] {
    MODE_BLANK  = 2'd0,
    MODE_SYNC   = 2'd1,
    MODE_BURST  = 2'd2,
    MODE_ACTIVE = 2'd3
  } mode_t;

  mode_t      mode_d, mode_q;
  logic [7:0] y_d, y_q;
  logic [7:0] a_d, a_q;
  logic [2:0] hue_d;
  logic [2:0] idx_d, idx_q;
  logic       xs1_q;

  logic [7:0] dac_d, dac_q;
  logic       xs2_q;

  // Stage 1: mode priority and colour lookup
  always_comb begin
    mode_d = MODE_BLANK;
    y_d    = 8'd0;
    a_d    = 8'd0;
    hue_d  = 3'd0;
    if (!XSYNC_i) begin
      mode_d = MODE_SYNC;
    end else if (CBURST_NOW_i) begin
      mode_d = MODE_BURST;
      a_d    = C_BURST_AMP;
      hue_d  = C_BURST_HUE;
    end else if (XBLK_i) begin
      mode_d = MODE_ACTIVE;
      case (PIX_RGBs_i)
        3'b001:  begin y_d = 8'd16;  a_d = 8'd44; hue_d = 3'd0; end
        3'b010:  begin y_d = 8'd82;  a_d = 8'd58; hue_d = 3'd5; end
        3'b011:  begin y_d = 8'd98;  a_d = 8'd62; hue_d = 3'd6; end
        3'b100:  begin y_d = 8'd42;  a_d = 8'd62; hue_d = 3'd2; end
        3'b101:  begin y_d = 8'd58;  a_d = 8'd58; hue_d = 3'd1; end
        3'b110:  begin y_d = 8'd124; a_d = 8'd44; hue_d = 3'd4; end
        3'b111:  begin y_d = 8'd140; a_d = 8'd0;  hue_d = 3'd0; end
        default: begin y_d = 8'd0;   a_d = 8'd0;  hue_d = 3'd0; end
      endcase
    end
    idx_d = CPHs_i + hue_d;
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      mode_q <= MODE_BLANK;
      y_q    <= 8'd0;
      a_q    <= 8'd0;
      idx_q  <= 3'd0;
      xs1_q  <= 1'b1;
    end else if (CK_EE_i) begin
      mode_q <= mode_d;
      y_q    <= y_d;
      a_q    <= a_d;
      idx_q  <= idx_d;
      xs1_q  <= XSYNC_i;
    end
  end

  // Stage 2: A*sin(45 deg) approximated as (A*181)>>8
  logic [15:0]        prod;
  logic [7:0]         m_val;
  logic signed [10:0] c_val;
  logic signed [10:0] sum;

  assign prod  = {8'd0, a_q} * 16'd181;
  assign m_val = prod[15:8];

  always_comb begin
    c_val = 11'sd0;
    case (idx_q)
      3'd1, 3'd3: c_val =  $signed({3'b000, m_val});
      3'd2:       c_val =  $signed({3'b000, a_q});
      3'd5, 3'd7: c_val = -$signed({3'b000, m_val});
      3'd6:       c_val = -$signed({3'b000, a_q});
      default:    c_val = 11'sd0;
    endcase
  end

  assign sum = $signed({3'b000, C_BLANK_LV}) + $signed({3'b000, y_q}) + c_val;

  always_comb begin
    dac_d = sum[7:0];
    if (mode_q == MODE_SYNC) begin
      dac_d = C_SYNC_LV;
    end else if (sum[10]) begin
      dac_d = 8'd0;
    end else if (sum > 11'sd255) begin
      dac_d = 8'd255;
    end
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      dac_q <= C_BLANK_LV;
      xs2_q <= 1'b1;
    end else if (CK_EE_i) begin
      dac_q <= dac_d;
      xs2_q <= xs1_q;
    end
  end

  assign DAC_o   = dac_q;
  assign XSYNC_o = xs2_q;

endmodule

// File: tb/tb_ntsc_composite_enc.sv
// Directed bench for ntsc_composite_enc: each vector's hand-computed DAC code
// is checked two clock edges after it is applied.
module tb_ntsc_composite_enc;

  logic       CK_i = 1'b0;
  logic       RST_i;
  logic       CK_EE_i;
  logic       XSYNC_i;
  logic       XBLK_i;
  logic       CBURST_NOW_i;
  logic [2:0] CPHs_i;
  logic [2:0] PIX_RGBs_i;
  logic [7:0] DAC_o;
  logic       XSYNC_o;

  int tests = 0;
  int fails = 0;

  ntsc_composite_enc dut (
    .CK_i         (CK_i),
    .RST_i        (RST_i),
    .CK_EE_i      (CK_EE_i),
    .XSYNC_i      (XSYNC_i),
    .XBLK_i       (XBLK_i),
    .CBURST_NOW_i (CBURST_NOW_i),
    .CPHs_i       (CPHs_i),
    .PIX_RGBs_i   (PIX_RGBs_i),
    .DAC_o        (DAC_o),
    .XSYNC_o      (XSYNC_o)
  );

  always #5 CK_i = ~CK_i;

  task automatic tick();
    @(posedge CK_i);
    #1;
  endtask

  task automatic drv(input logic xs, input logic blk, input logic bur,
                     input logic [2:0] cph, input logic [2:0] rgb);
    XSYNC_i      = xs;
    XBLK_i       = blk;
    CBURST_NOW_i = bur;
    CPHs_i       = cph;
    PIX_RGBs_i   = rgb;
  endtask

  task automatic check(input string tag, input logic [7:0] exp_dac, input logic exp_xs);
    tests++;
    assert (DAC_o === exp_dac) else begin
      fails++;
      $error("FAIL %s DAC_o got %0d expected %0d", tag, DAC_o, exp_dac);
    end
    tests++;
    assert (XSYNC_o === exp_xs) else begin
      fails++;
      $error("FAIL %s XSYNC_o got %b expected %b", tag, XSYNC_o, exp_xs);
    end
    $display("[TB] %-10s DAC_o=%0d XSYNC_o=%b (exp %0d/%b)", tag, DAC_o, XSYNC_o, exp_dac, exp_xs);
  endtask

  initial begin
    RST_i   = 1'b1;
    CK_EE_i = 1'b1;
    drv(0, 1, 1, 3'd2, 3'd7);
    tick(); check("rst_0", 8'd72, 1'b1);
    drv(1, 1, 0, 3'd5, 3'd4);
    CK_EE_i = 1'b0;
    tick(); check("rst_1", 8'd72, 1'b1);
    drv(1, 0, 1, 3'd6, 3'd3);
    CK_EE_i = 1'b1;
    tick(); check("rst_2", 8'd72, 1'b1);

    RST_i = 1'b0;
    drv(1, 1, 0, 3'd0, 3'd7);
    tick();
    drv(1, 1, 0, 3'd0, 3'd0);
    tick(); check("post_rst", 8'd212, 1'b1);

    drv(0, 1, 1, 3'd0, 3'd7);
    tick(); check("black", 8'd72, 1'b1);
    drv(1, 0, 0, 3'd0, 3'd0);
    tick(); check("sync_pri", 8'd0, 1'b0);

    drv(1, 0, 1, 3'd0, 3'd0);
    tick(); check("sync_end", 8'd72, 1'b1);
    drv(1, 0, 1, 3'd2, 3'd0);
    tick(); check("burst_0", 8'd72, 1'b1);
    drv(1, 0, 1, 3'd4, 3'd0);
    tick(); check("burst_2", 8'd44, 1'b1);
    drv(1, 0, 1, 3'd6, 3'd0);
    tick(); check("burst_4", 8'd72, 1'b1);
    drv(1, 0, 1, 3'd7, 3'd0);
    tick(); check("burst_6", 8'd100, 1'b1);

    drv(1, 1, 0, 3'd0, 3'd4);
    tick(); check("burst_7", 8'd91, 1'b1);
    drv(1, 1, 0, 3'd4, 3'd4);
    tick(); check("red_0", 8'd176, 1'b1);
    drv(1, 1, 0, 3'd4, 3'd6);
    tick(); check("red_4", 8'd52, 1'b1);
    drv(1, 1, 0, 3'd6, 3'd6);
    tick(); check("yel_4", 8'd196, 1'b1);
    drv(1, 1, 0, 3'd3, 3'd3);
    tick(); check("yel_6", 8'd240, 1'b1);
    drv(1, 1, 0, 3'd7, 3'd3);
    tick(); check("cyan_3", 8'd213, 1'b1);
    drv(1, 1, 0, 3'd5, 3'd7);
    tick(); check("cyan_7", 8'd127, 1'b1);

    drv(1, 0, 1, 3'd0, 3'd0);
    tick(); check("white_5", 8'd212, 1'b1);
    drv(1, 0, 1, 3'd2, 3'd0);
    tick(); check("ce_b0", 8'd72, 1'b1);
    drv(1, 0, 1, 3'd6, 3'd0);
    tick(); check("ce_b2", 8'd44, 1'b1);

    // Stage 1 now holds burst phase 6; stall with changing inputs
    CK_EE_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv(0, 1, 1, 3'(i + 1), 3'd7);
      tick(); check("ce_hold", 8'd44, 1'b1);
    end
    CK_EE_i = 1'b1;
    drv(1, 0, 1, 3'd7, 3'd0);
    tick(); check("ce_b6", 8'd100, 1'b1);
    drv(1, 0, 0, 3'd0, 3'd0);
    tick(); check("ce_b7", 8'd91, 1'b1);
    tick(); check("ce_blank", 8'd72, 1'b1);

    drv(1, 1, 0, 3'd0, 3'd7);
    tick();
    RST_i = 1'b1;
    tick(); check("rst_mid", 8'd72, 1'b1);
    RST_i = 1'b0;
    drv(1, 1, 0, 3'd4, 3'd6);
    tick(); check("rel_1", 8'd72, 1'b1);
    tick(); check("rel_2", 8'd196, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
